// File: rtl/watchdog_multi.sv
// Multi-channel windowed watchdog: each enabled channel must be kicked inside
// [WIN_MIN, TIMEOUT) ticks of the shared prescaler, else a sticky fault latches.
module watchdog_multi #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned TIMEOUT  = 32'd2400000000,
   parameter int unsigned WIN_MIN  = 0,
   parameter int unsigned PRESCALE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   input  logic [NUM_CH-1:0] kick,
   input  logic              clr,
   output logic [NUM_CH-1:0] err_late,
   output logic [NUM_CH-1:0] err_early,
   output logic [NUM_CH-1:0] err,
   output logic              err_any
);

   localparam int CW = $clog2(64'(TIMEOUT) + 64'd1);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WIN      = CW'(WIN_MIN);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   logic [PW-1:0] pre_q;
   logic          tick;
   state_t        state_q [NUM_CH];
   state_t        state_d [NUM_CH];
   logic [CW-1:0] cnt_q   [NUM_CH];
   logic [CW-1:0] cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] late_d, early_d, err_d;

   assign tick = (pre_q == PRE_LAST);

   // Shared prescaler; only rst may realign it so all channels see the same tick phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         err_late  <= '0;
         err_early <= '0;
         err       <= '0;
         err_any   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         err_late  <= late_d;
         err_early <= early_d;
         err       <= err_d;
         err_any   <= |err_d;
      end
   end

   // Per-channel next state; a kick on the expiring tick wins because it is tested first.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         late_d[i]  = err_late[i];
         early_d[i] = err_early[i];
         if (!en[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            if (clr) begin
               late_d[i]  = 1'b0;
               early_d[i] = 1'b0;
            end
         end else if (clr) begin
            state_d[i] = ARMED;
            cnt_d[i]   = '0;
            late_d[i]  = 1'b0;
            early_d[i] = 1'b0;
         end else begin
            case (state_q[i])
               IDLE: begin
                  state_d[i] = ARMED;
                  cnt_d[i]   = '0;
               end
               ARMED: begin
                  if (kick[i]) begin
                     cnt_d[i] = '0;
                     if ((WIN_MIN != 0) && (cnt_q[i] < WIN)) begin
                        early_d[i] = 1'b1;
                     end
                  end else if (tick) begin
                     if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = EXPIRED;
                        late_d[i]  = 1'b1;
                     end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                     end
                  end
               end
               EXPIRED: begin
                  state_d[i] = EXPIRED;
               end
               default: begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
      err_d = late_d | early_d;
   end

endmodule
